pixel_sum_stream: RTL and testbench
===================================

PIXEL_SUM_STREAM -- requirements
Module: pixel_sum_stream

Interface
REQ-001 SHALL have parameter HEIGHT, default 28: image rows.
REQ-002 SHALL have parameter LENGTH, default 28: image columns; SHALL be a multiple of LANES.
REQ-003 SHALL have parameter PIX_W, default 1: unsigned pixel width in bits.
REQ-004 SHALL have parameter LANES, default 4: pixels accepted per beat.
REQ-005 SHALL have parameter SUM_W, default 32: width of every sum output.
REQ-006 SHALL have ports clk (input, 1, clock) and rst (input, 1, asynchronous active-high reset), with one clock and all logic on rising clk.
REQ-007 SHALL have port in_valid (input, 1): pixel beat valid.
REQ-008 SHALL have port in_ready (output, 1): beat accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_pixels (input, LANES*PIX_W): lane k occupies bits [k*PIX_W +: PIX_W], and lane 0 is the leftmost column.
REQ-010 SHALL have port out_valid (output, 1): frame result valid.
REQ-011 SHALL have port out_ready (input, 1): result consumed when out_valid and out_ready are both high.
REQ-012 SHALL have port sum (output, SUM_W): sum of all frame pixels.
REQ-013 SHALL have port sum_left (output, SUM_W): sum of pixels in columns 0 .. LENGTH/2-1 (floor).
REQ-014 SHALL have port overflow (output, 1): a sum wrapped during this frame.

Function
REQ-015 SHALL stream frames in row-major order, each frame being HEIGHT*LENGTH/LANES beats, with no framing signal; frames are delimited by internal row and beat counters.
REQ-016 SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-017 In IDLE, SHALL take the first accepted beat into the cleared accumulators and go to ACCUM; when the frame is one beat long, SHALL go directly to DONE.
REQ-018 In ACCUM, SHALL add each accepted beat; acceptance of the last beat (last row, last column beat) SHALL cause a move to DONE.
REQ-019 In DONE, SHALL hold out_valid high with sum, sum_left and overflow stable until out_ready; the handshake cycle SHALL clear the accumulators and counters and return to IDLE.
REQ-020 SHALL drive in_ready high in IDLE and ACCUM and low in DONE; no beat SHALL be accepted in the handshake cycle.
REQ-021 Latency: out_valid SHALL rise on the clock edge that accepts the last beat, so it is visible the following cycle.
REQ-022 Per beat, SHALL add the sum of all LANES lanes to sum, and SHALL add lane k to sum_left iff (column beat index*LANES + k) < LENGTH/2.
REQ-023 Arithmetic SHALL be unsigned and modulo 2^SUM_W; overflow SHALL be set sticky on any carry out of either sum and cleared at the output handshake.
REQ-024 When in_valid is low, SHALL leave state, counters and sums unchanged (bubbles allowed anywhere in a frame).

Reset
REQ-025 rst SHALL asynchronously force IDLE, zero counters, and set sum=0, sum_left=0, overflow=0, out_valid=0 and in_ready=0 while asserted; in_ready SHALL go to 1 in the first cycle after release.
REQ-026 A reset mid-frame or in DONE SHALL discard the partial or pending result.

Configuration
REQ-027 Macro PIXEL_SUM_ROW_SUMS_EN, when defined, SHALL add outputs row_valid (1) and row_sum (SUM_W), and row_sum SHALL carry the completed row's sum.
REQ-028 With that macro defined, row_valid SHALL pulse for one cycle after each row's last beat, with no backpressure, including the final row coincident with out_valid rising.
REQ-029 When the macro is undefined, those ports and the row accumulator SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 The shared package pixel_sum_pkg SHALL hold the FSM state enum and the default image constants HEIGHT=28 and LENGTH=28.
REQ-031 One sub-module, pixel_lane_adder, SHALL hold the combinational per-beat lane sum and left-masked lane sum, parameterised by LANES, PIX_W, LENGTH and column beat index.

Verification
REQ-032 The bench SHALL drive HEIGHT=2, LENGTH=4, LANES=2, PIX_W=1 with all-ones, gapless input, and SHALL see sum=8, sum_left=4 and out_valid the cycle after beat 4.
REQ-033 The bench SHALL drive rows 1,0,0,1 / 0,1,1,0 with in_valid toggling every cycle, and SHALL see sum=4, sum_left=2 and no beat lost or duplicated.
REQ-034 The bench SHALL hold out_ready low for 5 cycles in DONE, and SHALL see in_ready=0, the outputs stable, and the next frame accepted only after the handshake.
REQ-035 The bench SHALL use PIX_W=8, SUM_W=8 with all pixels 255, and SHALL see sum wrap and overflow=1, with overflow=0 after the handshake.
REQ-036 The bench SHALL assert rst after beat 2 of 4, then send a fresh all-ones frame, and SHALL see sum=8 with no residue.
REQ-037 With PIXEL_SUM_ROW_SUMS_EN and the REQ-033 input, the bench SHALL see row_valid pulses with row_sum=2, then 2.

Source files
------------

// File: rtl/pixel_sum_pkg.sv
// Shared FSM state type and default image geometry for the pixel sum stream.
package pixel_sum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int IMG_HEIGHT = 28;
  localparam int IMG_LENGTH = 28;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_lane_adder.sv
// Combinational per-beat lane sum plus the sum of lanes that fall in the left half.
module pixel_lane_adder #(
  parameter int LANES  = 4,
  parameter int PIX_W  = 1,
  parameter int LENGTH = 28,
  parameter int BW     = 3,
  parameter int LW     = 4
) (
  input  logic [LANES*PIX_W-1:0] i_pixels,
  input  logic [BW-1:0]          i_beatIdx,
  output logic [LW-1:0]          o_laneSum,
  output logic [LW-1:0]          o_leftSum
);

  // Lane k sits in column beatIdx*LANES + k; lane 0 is the leftmost column.
  always_comb begin
    o_laneSum = '0;
    o_leftSum = '0;
    for (int k = 0; k < LANES; k++) begin
      o_laneSum = o_laneSum + LW'(i_pixels[k*PIX_W +: PIX_W]);
      if ((int'(i_beatIdx) * LANES + k) < (LENGTH / 2))
        o_leftSum = o_leftSum + LW'(i_pixels[k*PIX_W +: PIX_W]);
    end
  end

endmodule

// File: rtl/pixel_sum_stream.sv
// Streams HEIGHT x LENGTH frames LANES pixels per beat and reports whole/left-half sums.
// Optional per-row sums are enabled with the PIXEL_SUM_ROW_SUMS_EN macro.
module pixel_sum_stream
  import pixel_sum_pkg::*;
#(
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int LENGTH = IMG_LENGTH,
  parameter int PIX_W  = 1,
  parameter int LANES  = 4,
  parameter int SUM_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] in_pixels,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_W-1:0]       sum,
  output logic [SUM_W-1:0]       sum_left,
  output logic                   overflow
`ifdef PIXEL_SUM_ROW_SUMS_EN
  ,
  output logic                   row_valid,
  output logic [SUM_W-1:0]       row_sum
`endif
);

  localparam int BPR = LENGTH / LANES;
  localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LW  = PIX_W + $clog2(LANES + 1);
  localparam int EW  = maxInt(LW, SUM_W) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [BW-1:0]    r_beat;
  logic [RW-1:0]    r_row;
  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] r_sumLeft;
  logic             r_overflow;
  logic             w_accept;
  logic             w_handshake;
  logic             w_rowEnd;
  logic             w_lastBeat;
  logic [LW-1:0]    w_laneSum;
  logic [LW-1:0]    w_leftSum;
  logic [SUM_W-1:0] w_sumBase;
  logic [SUM_W-1:0] w_leftBase;
  logic             w_ovfBase;
  logic [EW-1:0]    w_sumExt;
  logic [EW-1:0]    w_leftExt;
  logic             w_carry;

  pixel_lane_adder #(
    .LANES (LANES),
    .PIX_W (PIX_W),
    .LENGTH(LENGTH),
    .BW    (BW),
    .LW    (LW)
  ) u_laneAdder (
    .i_pixels (in_pixels),
    .i_beatIdx(r_beat),
    .o_laneSum(w_laneSum),
    .o_leftSum(w_leftSum)
  );

  // Ready drops combinationally with reset so nothing is taken while it is held.
  assign in_ready    = ~rst & (r_state != DONE);
  assign out_valid   = (r_state == DONE);
  assign w_accept    = in_valid & in_ready;
  assign w_handshake = (r_state == DONE) & out_ready;
  assign w_rowEnd    = (r_beat == BW'(BPR - 1));
  assign w_lastBeat  = w_rowEnd & (r_row == RW'(HEIGHT - 1));

  assign w_sumBase  = (r_state == IDLE) ? '0 : r_sum;
  assign w_leftBase = (r_state == IDLE) ? '0 : r_sumLeft;
  assign w_ovfBase  = (r_state == IDLE) ? 1'b0 : r_overflow;
  assign w_sumExt   = EW'(w_sumBase) + EW'(w_laneSum);
  assign w_leftExt  = EW'(w_leftBase) + EW'(w_leftSum);
  assign w_carry    = (|w_sumExt[EW-1:SUM_W]) | (|w_leftExt[EW-1:SUM_W]);

  assign sum      = r_sum;
  assign sum_left = r_sumLeft;
  assign overflow = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_lastBeat ? DONE : ACCUM;
      ACCUM:   if (w_accept && w_lastBeat) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat     <= '0;
      r_row      <= '0;
      r_sum      <= '0;
      r_sumLeft  <= '0;
      r_overflow <= 1'b0;
    end else if (w_handshake) begin
      r_beat     <= '0;
      r_row      <= '0;
      r_sum      <= '0;
      r_sumLeft  <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_sum      <= w_sumExt[SUM_W-1:0];
      r_sumLeft  <= w_leftExt[SUM_W-1:0];
      r_overflow <= w_ovfBase | w_carry;
      if (w_rowEnd) begin
        r_beat <= '0;
        r_row  <= w_lastBeat ? '0 : r_row + 1'b1;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

`ifdef PIXEL_SUM_ROW_SUMS_EN
  logic [SUM_W-1:0] r_rowAcc;
  logic [SUM_W-1:0] w_rowNext;

  assign w_rowNext = r_rowAcc + SUM_W'(w_laneSum);

  // Row result is published the cycle after its last beat, with no backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rowAcc  <= '0;
      row_valid <= 1'b0;
      row_sum   <= '0;
    end else begin
      row_valid <= 1'b0;
      if (w_handshake) begin
        r_rowAcc <= '0;
      end else if (w_accept) begin
        if (w_rowEnd) begin
          row_valid <= 1'b1;
          row_sum   <= w_rowNext;
          r_rowAcc  <= '0;
        end else begin
          r_rowAcc <= w_rowNext;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_sum_stream.sv
// Directed scoreboard bench: two 2x4 instances, one 1-bit/32-bit sums and one 8-bit/8-bit sums.
module tb_pixel_sum_stream;

  localparam int H   = 2;
  localparam int L   = 4;
  localparam int LN  = 2;
  localparam int BPR = L / LN;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        aValid, aReady, aOutValid, aOutReady, aOvf;
  logic [1:0]  aPix;
  logic [31:0] aSum, aLeft;
  logic        bValid, bReady, bOutValid, bOutReady, bOvf;
  logic [15:0] bPix;
  logic [7:0]  bSum, bLeft;
`ifdef PIXEL_SUM_ROW_SUMS_EN
  logic        aRowValid, bRowValid;
  logic [31:0] aRowSum;
  logic [7:0]  bRowSum;
`endif

  pixel_sum_stream #(.HEIGHT(H), .LENGTH(L), .PIX_W(1), .LANES(LN), .SUM_W(32)) dutA (
    .clk(clk), .rst(rst), .in_valid(aValid), .in_ready(aReady), .in_pixels(aPix),
    .out_valid(aOutValid), .out_ready(aOutReady), .sum(aSum), .sum_left(aLeft),
    .overflow(aOvf)
`ifdef PIXEL_SUM_ROW_SUMS_EN
    , .row_valid(aRowValid), .row_sum(aRowSum)
`endif
  );

  pixel_sum_stream #(.HEIGHT(H), .LENGTH(L), .PIX_W(8), .LANES(LN), .SUM_W(8)) dutB (
    .clk(clk), .rst(rst), .in_valid(bValid), .in_ready(bReady), .in_pixels(bPix),
    .out_valid(bOutValid), .out_ready(bOutReady), .sum(bSum), .sum_left(bLeft),
    .overflow(bOvf)
`ifdef PIXEL_SUM_ROW_SUMS_EN
    , .row_valid(bRowValid), .row_sum(bRowSum)
`endif
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] l;
    logic        o;
  } exp_t;

  exp_t        expA[$];
  exp_t        expB[$];
  logic [31:0] rowQ[$];
  int          pix[H][L];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic getReady(input int w);
    return (w == 0) ? aReady : bReady;
  endfunction

  function automatic logic getOutValid(input int w);
    return (w == 0) ? aOutValid : bOutValid;
  endfunction

  function automatic logic getOvf(input int w);
    return (w == 0) ? aOvf : bOvf;
  endfunction

  function automatic logic [31:0] getSum(input int w);
    return (w == 0) ? aSum : {24'd0, bSum};
  endfunction

  function automatic logic [31:0] getLeft(input int w);
    return (w == 0) ? aLeft : {24'd0, bLeft};
  endfunction

  task automatic setPixels(input int r0a, input int r0b, input int r0c, input int r0d,
                           input int r1a, input int r1b, input int r1c, input int r1d);
    pix[0][0] = r0a; pix[0][1] = r0b; pix[0][2] = r0c; pix[0][3] = r0d;
    pix[1][0] = r1a; pix[1][1] = r1b; pix[1][2] = r1c; pix[1][3] = r1d;
  endtask

  task automatic driveBeat(input int w, input logic [15:0] px);
    int n = 0;
    if (w == 0) begin aValid = 1'b1; aPix = px[1:0]; end
    else        begin bValid = 1'b1; bPix = px;      end
    while (getReady(w) !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_in_ready", {31'd0, getReady(w)}, 32'd1);
    @(posedge clk); #1;
    if (w == 0) begin aValid = 1'b0; aPix = '1; end
    else        begin bValid = 1'b0; bPix = '1; end
  endtask

  // Pushes the model's frame (and row) results, then drives nBeats of the current pix frame.
  task automatic applyStimulus(input int w, input bit gaps, input int nBeats);
    longint      s = 0, l = 0, rs, lim;
    int          pw, beat;
    logic [15:0] px;
    exp_t        e;
    pw   = (w == 0) ? 1 : 8;
    lim  = (w == 0) ? 64'h1_0000_0000 : 64'd256;
    beat = 0;
    for (int r = 0; r < H; r++) begin
      rs = 0;
      for (int c = 0; c < L; c++) begin
        s  += pix[r][c];
        rs += pix[r][c];
        if (c < L / 2) l += pix[r][c];
      end
      if (w == 0 && (r + 1) * BPR <= nBeats) rowQ.push_back(32'(rs % lim));
    end
    if (nBeats == H * BPR) begin
      e.s = 32'(s % lim);
      e.l = 32'(l % lim);
      e.o = (s >= lim) || (l >= lim);
      if (w == 0) expA.push_back(e);
      else        expB.push_back(e);
    end
    for (int r = 0; r < H; r++) begin
      for (int b = 0; b < BPR; b++) begin
        if (beat < nBeats) begin
          px = '0;
          for (int k = 0; k < LN; k++) px |= 16'(pix[r][b*LN + k]) << (k * pw);
          if (beat == H * BPR - 1) chk("out_valid_before_last", {31'd0, getOutValid(w)}, 32'd0);
          driveBeat(w, px);
          if (gaps && beat != nBeats - 1) begin @(posedge clk); #1; end
          beat++;
        end
      end
    end
    if (nBeats == H * BPR) chk("out_valid_latency", {31'd0, getOutValid(w)}, 32'd1);
  endtask

  // Pops the scoreboard, holds out_ready low for hold cycles (optionally offering a beat), then handshakes.
  task automatic checkOutput(input int w, input int hold, input bit pend, input logic [1:0] pendPx);
    exp_t e;
    int   n = 0;
    while (getOutValid(w) !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid", {31'd0, getOutValid(w)}, 32'd1);
    if (((w == 0) ? expA.size() : expB.size()) == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1 entries");
      return;
    end
    e = (w == 0) ? expA.pop_front() : expB.pop_front();
    if (pend) begin aValid = 1'b1; aPix = pendPx; end
    for (int i = 0; i <= hold; i++) begin
      chk("sum", getSum(w), e.s);
      chk("sum_left", getLeft(w), e.l);
      chk("overflow", {31'd0, getOvf(w)}, {31'd0, e.o});
      chk("in_ready_done", {31'd0, getReady(w)}, 32'd0);
      chk("out_valid_hold", {31'd0, getOutValid(w)}, 32'd1);
      if (i < hold) begin @(posedge clk); #1; end
    end
    if (w == 0) aOutReady = 1'b1; else bOutReady = 1'b1;
    @(posedge clk); #1;
    if (w == 0) aOutReady = 1'b0; else bOutReady = 1'b0;
    chk("out_valid_after_hs", {31'd0, getOutValid(w)}, 32'd0);
    chk("overflow_after_hs", {31'd0, getOvf(w)}, 32'd0);
    chk("sum_after_hs", getSum(w), 32'd0);
    chk("in_ready_after_hs", {31'd0, getReady(w)}, 32'd1);
  endtask

`ifdef PIXEL_SUM_ROW_SUMS_EN
  always @(negedge clk) begin
    logic [31:0] re;
    if (rst === 1'b0 && aRowValid === 1'b1) begin
      if (rowQ.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL row_unexpected observed=%0d expected=none", aRowSum);
      end else begin
        re = rowQ.pop_front();
        chk("row_sum", aRowSum, re);
      end
    end
  end
`endif

  initial begin
    aValid = 1'b0; aPix = '0; aOutReady = 1'b0;
    bValid = 1'b0; bPix = '0; bOutReady = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_a", {31'd0, aReady}, 32'd0);
    chk("rst_out_valid_a", {31'd0, aOutValid}, 32'd0);
    chk("rst_sum_a", aSum, 32'd0);
    chk("rst_in_ready_b", {31'd0, bReady}, 32'd0);
    rst = 1'b0;
    #1;
    chk("release_in_ready_a", {31'd0, aReady}, 32'd1);
    chk("release_in_ready_b", {31'd0, bReady}, 32'd1);

    $display("[TB] all-ones gapless frame with 5-cycle backpressure");
    setPixels(1, 1, 1, 1, 1, 1, 1, 1);
    applyStimulus(0, 1'b0, 4);
    checkOutput(0, 5, 1'b1, 2'b01);

    $display("[TB] checker pattern with in_valid toggling");
    setPixels(1, 0, 0, 1, 0, 1, 1, 0);
    applyStimulus(0, 1'b1, 4);
    checkOutput(0, 0, 1'b0, 2'b00);

    $display("[TB] reset mid-frame then fresh frame");
    setPixels(1, 1, 1, 1, 1, 1, 1, 1);
    applyStimulus(0, 1'b0, 2);
    @(negedge clk); #1;
    rst = 1'b1;
    #2;
    chk("midrst_sum", aSum, 32'd0);
    chk("midrst_left", aLeft, 32'd0);
    chk("midrst_in_ready", {31'd0, aReady}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", {31'd0, aReady}, 32'd1);
    applyStimulus(0, 1'b0, 4);
    checkOutput(0, 0, 1'b0, 2'b00);

    $display("[TB] 8-bit saturating-width frame, wrap and overflow");
    setPixels(255, 255, 255, 255, 255, 255, 255, 255);
    applyStimulus(1, 1'b0, 4);
    checkOutput(1, 2, 1'b0, 2'b00);
    setPixels(1, 1, 1, 1, 1, 1, 1, 1);
    applyStimulus(1, 1'b1, 4);
    checkOutput(1, 0, 1'b0, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_a_drained", expA.size(), 32'd0);
    chk("scoreboard_b_drained", expB.size(), 32'd0);
`ifdef PIXEL_SUM_ROW_SUMS_EN
    chk("row_queue_drained", rowQ.size(), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
